// File: rtl/intpol2_d4_pkg.sv
// ============================================================================
// Module      : intpol2_d4_pkg
// Description : Shared definitions for the second-order interpolation
//               difference scheduler: FSM state encoding, default widths
//               and the coefficient-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intpol2_d4_pkg;

  // Default sample width and integer guard bits.
  localparam int DEF_DATAPATH_WIDTH = 32;
  localparam int DEF_N_BITS         = 2;

  // Scheduler states, 3-bit encoding. Codes 6 and 7 are unused.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ISS1 = 3'd1,
    ST_ISS2 = 3'd2,
    ST_ISS3 = 3'd3,
    ST_CAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Coefficient / subtractor width: sample width plus guard bits.
  function automatic int coef_width(input int dw, input int nb);
    return dw + nb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/intpol2_d4_diff_sched.sv
// ============================================================================
// Module      : intpol2_d4_diff_sched
// Description : Time-shares one external registered subtractor to compute
//               the second-order interpolation coefficients of a sample
//               triplet: c0 = y0, d1 = y1-y0, d2 = (y2-y1)-(y1-y0).
// Revision    : 1.0 - initial release
//
// Build option: INTPOL2_D4_HALF_EN - when defined, d2 is delivered as
//               floor(d2/2) (arithmetic shift), i.e. the Newton coefficient.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   in_valid / in_ready     triplet handshake; y0, y1, y2 sampled on accept
//   sub_en, sub_a, sub_b    drive the external subtractor (sub_a - sub_b)
//   sub_c                   registered subtractor result
//   out_valid / out_ready   coefficient handshake; c0, d1, d2 held while valid
//   busy                    high whenever a triplet is in flight
// ============================================================================
`default_nettype none

module intpol2_d4_diff_sched
  import intpol2_d4_pkg::*;
#(
  parameter  int DATAPATH_WIDTH = DEF_DATAPATH_WIDTH,
  parameter  int N_bits         = DEF_N_BITS,
  localparam int W              = coef_width(DATAPATH_WIDTH, N_bits)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATAPATH_WIDTH-1:0] y0,
  input  logic signed [DATAPATH_WIDTH-1:0] y1,
  input  logic signed [DATAPATH_WIDTH-1:0] y2,
  output logic                             sub_en,
  output logic signed [W-1:0]              sub_a,
  output logic signed [W-1:0]              sub_b,
  input  logic signed [W-1:0]              sub_c,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [W-1:0]              c0,
  output logic signed [W-1:0]              d1,
  output logic signed [W-1:0]              d2,
  output logic                             busy
);

  state_e              state, state_nxt;
  logic signed [W-1:0] y0_r, y1_r, y2_r;
  logic signed [W-1:0] d1_r;
  logic signed [W-1:0] c0_q, d1_q, d2_q;
  logic signed [W-1:0] d2_load;

  // Next-state logic: a fixed three-issue sequence between the handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_ISS1;
      ST_ISS1:                state_nxt = ST_ISS2;
      ST_ISS2:                state_nxt = ST_ISS3;
      ST_ISS3:                state_nxt = ST_CAP;
      ST_CAP:                 state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Subtractor operand mux. In ISS3 the minuend is the live subtractor
  // output (y2-y1, registered at the end of ISS2); sub_c is a register,
  // so this path is not a combinational loop.
  always_comb begin
    sub_en = 1'b0;
    sub_a  = '0;
    sub_b  = '0;
    case (state)
      ST_ISS1: begin sub_en = 1'b1; sub_a = y1_r;  sub_b = y0_r; end
      ST_ISS2: begin sub_en = 1'b1; sub_a = y2_r;  sub_b = y1_r; end
      ST_ISS3: begin sub_en = 1'b1; sub_a = sub_c; sub_b = d1_r; end
      default: ;
    endcase
  end

  // In CAP, sub_c carries d2 itself, so it is loaded straight into the
  // output register instead of passing through an intermediate stage.
`ifdef INTPOL2_D4_HALF_EN
  assign d2_load = sub_c >>> 1;
`else
  assign d2_load = sub_c;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      y0_r  <= '0;
      y1_r  <= '0;
      y2_r  <= '0;
      d1_r  <= '0;
      c0_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            y0_r <= {{N_bits{y0[DATAPATH_WIDTH-1]}}, y0};
            y1_r <= {{N_bits{y1[DATAPATH_WIDTH-1]}}, y1};
            y2_r <= {{N_bits{y2[DATAPATH_WIDTH-1]}}, y2};
          end
        end
        ST_ISS2: d1_r <= sub_c;          // y1 - y0
        ST_CAP: begin
          c0_q <= y0_r;
          d1_q <= d1_r;
          d2_q <= d2_load;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign c0        = c0_q;
  assign d1        = d1_q;
  assign d2        = d2_q;

endmodule

`default_nettype wire

// File: tb/tb_intpol2_d4_diff_sched.sv
// ============================================================================
// Module      : tb_intpol2_d4_diff_sched
// Description : Self-checking bench for intpol2_d4_diff_sched with an
//               external registered subtractor and a 64-bit arithmetic
//               reference model. Honours INTPOL2_D4_HALF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intpol2_d4_diff_sched;

  localparam int DW = 32;
  localparam int NB = 2;
  localparam int W  = DW + NB;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] y0, y1, y2;
  logic                 sub_en;
  logic signed [W-1:0]  sub_a, sub_b, sub_c;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  c0, d1, d2;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  intpol2_d4_diff_sched #(.DATAPATH_WIDTH(DW), .N_bits(NB)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2),
    .sub_en(sub_en), .sub_a(sub_a), .sub_b(sub_b), .sub_c(sub_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .c0(c0), .d1(d1), .d2(d2), .busy(busy)
  );

  // External registered subtractor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       sub_c <= '0;
    else if (sub_en) sub_c <= sub_a - sub_b;
  end

  function automatic longint sx(input logic signed [W-1:0] v);
    return longint'(v);
  endfunction

  // Reference: c0 = y0, d1 = y1-y0, d2 = y2-2*y1+y0 (optionally floor(d2/2)).
  function automatic void model(input longint a, input longint b, input longint c,
                                output longint e1, output longint e2);
    e1 = b - a;
    e2 = c - 2 * b + a;
`ifdef INTPOL2_D4_HALF_EN
    e2 = e2 >>> 1;
`endif
  endfunction

  function automatic longint rnd();
    return longint'($signed($urandom()));
  endfunction

  // Drive one triplet from a negedge while the DUT is idle; returns at the
  // negedge of cycle T+1 with in_valid dropped.
  task automatic accept(input longint a, input longint b, input longint c);
    y0 = a[DW-1:0]; y1 = b[DW-1:0]; y2 = c[DW-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    y0 = '0; y1 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, sub_en} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready/out_valid/busy/sub_en=%b want 1000",
               {in_ready, out_valid, busy, sub_en});
    end
    checks++;
    if (sub_a !== '0 || sub_b !== '0 || c0 !== '0 || d1 !== '0 || d2 !== '0) begin
      errors++;
      $display("FAIL reset_data got sub_a=%0d sub_b=%0d c0=%0d d1=%0d d2=%0d want all 0",
               sx(sub_a), sx(sub_b), sx(c0), sx(d1), sx(d2));
    end
  endtask

  task automatic test_basic();
    longint e1, e2;
    int     en_cnt;
    model(10, 25, 47, e1, e2);
    out_ready = 1'b1;
    en_cnt = 0;
    accept(10, 25, 47);
    // Now in cycle T+1.
    for (int k = 1; k <= 5; k++) begin
      if (sub_en) en_cnt++;
      checks++;
      if (sub_en !== (k <= 3) || out_valid !== (k == 5)) begin
        errors++;
        $display("FAIL basic_timing cycle T+%0d got sub_en=%b out_valid=%b want %b %b",
                 k, sub_en, out_valid, (k <= 3), (k == 5));
      end
      if (k == 1) begin
        checks++;
        if (sx(sub_a) !== 25 || sx(sub_b) !== 10) begin
          errors++;
          $display("FAIL basic_ops got sub_a=%0d sub_b=%0d want 25 10", sx(sub_a), sx(sub_b));
        end
      end
      if (k < 5) @(negedge clk);
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL basic_en_count got %0d want 3", en_cnt);
    end
    checks++;
    if (sx(c0) !== 10 || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL basic_coef got c0=%0d d1=%0d d2=%0d want 10 %0d %0d",
               sx(c0), sx(d1), sx(d2), e1, e2);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_negative();
    longint e1, e2;
    bit     ok;
    model(100, 40, -30, e1, e2);
    out_ready = 1'b1;
    accept(100, 40, -30);
    @(negedge clk);  // T+2: sub_a = y2 = -30
    checks++;
    if (sx(sub_a) !== -30 || sx(sub_b) !== 40) begin
      errors++;
      $display("FAIL neg_sext got sub_a=%0d sub_b=%0d want -30 40", sx(sub_a), sx(sub_b));
    end
    @(negedge clk);  // T+3: sub_a = y2-y1, sub_b = d1
    checks++;
    if (sx(sub_a) !== -70 || sx(sub_b) !== -60) begin
      errors++;
      $display("FAIL neg_iss3 got sub_a=%0d sub_b=%0d want -70 -60", sx(sub_a), sx(sub_b));
    end
    wait_out(ok);
    checks++;
    if (!ok || sx(c0) !== 100 || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL neg_coef valid=%b got c0=%0d d1=%0d d2=%0d want 100 %0d %0d",
               ok, sx(c0), sx(d1), sx(d2), e1, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    longint a, b, e1, e2;
    bit     ok;
    a = -(64'sd1 <<< 31);
    b = (64'sd1 <<< 31) - 1;
    model(a, b, a, e1, e2);
    out_ready = 1'b1;
    accept(a, b, a);
    wait_out(ok);
    checks++;
    if (!ok || sx(c0) !== a || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL extreme_coef valid=%b got c0=%0d d1=%0d d2=%0d want %0d %0d %0d",
               ok, sx(c0), sx(d1), sx(d2), a, e1, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    longint a, b, c, e1, e2;
    bit     ok;
    int     stall;
    for (int n = 0; n < 16; n++) begin
      a = rnd(); b = rnd(); c = rnd();
      model(a, b, c, e1, e2);
      stall = $urandom_range(0, 3);
      out_ready = 1'b0;
      accept(a, b, c);
      wait_out(ok);
      repeat (stall) @(negedge clk);
      checks++;
      if (!ok || !out_valid || sx(c0) !== a || sx(d1) !== e1 || sx(d2) !== e2) begin
        errors++;
        $display("FAIL random_%0d valid=%b got c0=%0d d1=%0d d2=%0d want %0d %0d %0d",
                 n, out_valid, sx(c0), sx(d1), sx(d2), a, e1, e2);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    longint a, b, c, e1, e2;
    bit     ok;
    a = rnd(); b = rnd(); c = rnd();
    model(a, b, c, e1, e2);
    out_ready = 1'b0;
    accept(a, b, c);
    wait_out(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_valid got out_valid=0 want 1 within budget");
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (!out_valid || in_ready || !busy ||
          sx(c0) !== a || sx(d1) !== e1 || sx(d2) !== e2) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b ir=%b busy=%b c0=%0d d1=%0d d2=%0d want 1 0 1 %0d %0d %0d",
                 k, out_valid, in_ready, busy, sx(c0), sx(d1), sx(d2), a, e1, e2);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    longint e1, e2;
    bit     ok, seen;
    out_ready = 1'b1;
    accept(rnd(), rnd(), rnd());
    @(negedge clk);  // ISS2
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (sub_en || out_valid || busy || !in_ready || sub_a !== '0 || sub_b !== '0 ||
        c0 !== '0 || d1 !== '0 || d2 !== '0) begin
      errors++;
      $display("FAIL rstmid_clear got en=%b v=%b busy=%b ir=%b a=%0d b=%0d c0=%0d d1=%0d d2=%0d want 0 0 0 1 0s",
               sub_en, out_valid, busy, in_ready, sx(sub_a), sx(sub_b), sx(c0), sx(d1), sx(d2));
    end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_no_output got out_valid=1 want 0");
    end
    model(1, 2, 4, e1, e2);
    accept(1, 2, 4);
    wait_out(ok);
    checks++;
    if (!ok || sx(c0) !== 1 || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL rstmid_after valid=%b got c0=%0d d1=%0d d2=%0d want 1 %0d %0d",
               ok, sx(c0), sx(d1), sx(d2), e1, e2);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    longint a0, b0, c0x, a1, b1, c1, e1, e2;
    bit     ok;
    a0 = rnd(); b0 = rnd(); c0x = rnd();
    a1 = rnd(); b1 = rnd(); c1 = rnd();
    out_ready = 1'b1;
    y0 = a0[DW-1:0]; y1 = b0[DW-1:0]; y2 = c0x[DW-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    y0 = a1[DW-1:0]; y1 = b1[DW-1:0]; y2 = c1[DW-1:0];  // in_valid stays high
    wait_out(ok);
    model(a0, b0, c0x, e1, e2);
    checks++;
    if (!ok || in_ready || sx(c0) !== a0 || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL b2b_first valid=%b ir=%b got c0=%0d d1=%0d d2=%0d want %0d %0d %0d",
               ok, in_ready, sx(c0), sx(d1), sx(d2), a0, e1, e2);
    end
    @(negedge clk);  // one cycle after the output handshake
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || sub_en !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept got busy=%b sub_en=%b want 1 1", busy, sub_en);
    end
    wait_out(ok);
    model(a1, b1, c1, e1, e2);
    checks++;
    if (!ok || sx(c0) !== a1 || sx(d1) !== e1 || sx(d2) !== e2) begin
      errors++;
      $display("FAIL b2b_second valid=%b got c0=%0d d1=%0d d2=%0d want %0d %0d %0d",
               ok, sx(c0), sx(d1), sx(d2), a1, e1, e2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
